// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller: state encodings,
// display-select constants and the per-state control output decode.
package genius_pkg;

    localparam logic [2:0] ST_INIT      = 3'd0;
    localparam logic [2:0] ST_SETUP     = 3'd1;
    localparam logic [2:0] ST_PLAY_FPGA = 3'd2;
    localparam logic [2:0] ST_PLAY_USER = 3'd3;
    localparam logic [2:0] ST_CHECK     = 3'd4;
    localparam logic [2:0] ST_NEXT_RND  = 3'd5;
    localparam logic [2:0] ST_CHECK_WIN = 3'd6;
    localparam logic [2:0] ST_RESULT    = 3'd7;

    // Display select: status shows level/time/round, result shows points.
    localparam logic SEL_STATUS = 1'b1;
    localparam logic SEL_RESULT = 1'b0;

    typedef enum logic [2:0] {
        S_INIT      = ST_INIT,
        S_SETUP     = ST_SETUP,
        S_PLAY_FPGA = ST_PLAY_FPGA,
        S_PLAY_USER = ST_PLAY_USER,
        S_CHECK     = ST_CHECK,
        S_NEXT_RND  = ST_NEXT_RND,
        S_CHECK_WIN = ST_CHECK_WIN,
        S_RESULT    = ST_RESULT
    } state_t;

    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } ctrl_t;

    // Moore output table; anything not named for a state stays 0.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_INIT:      begin c.r1 = 1'b1; c.r2 = 1'b1; c.sel = SEL_RESULT; end
            S_SETUP:     begin c.e1 = 1'b1; c.sel = SEL_STATUS; end
            S_PLAY_FPGA: begin c.e3 = 1'b1; c.sel = SEL_STATUS; end
            S_PLAY_USER: begin c.e2 = 1'b1; c.sel = SEL_STATUS; end
            S_CHECK:     c.sel = SEL_STATUS;
            S_NEXT_RND:  begin c.e4 = 1'b1; c.r2 = 1'b1; c.sel = SEL_STATUS; end
            S_CHECK_WIN: c.sel = SEL_STATUS;
            S_RESULT:    c.sel = SEL_RESULT;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/genius_key_edge.sv
// Key synchronizer and falling-edge detector. Produces a registered
// one-cycle pulse per press, however long the key is held.
module key_edge
    import genius_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic key_n,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Synchronize, delay one cycle for edge compare, and only arm the
    // detector once both compared samples come from post-reset key data,
    // so a key held down across reset release is not seen as a press.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            fill_q     <= '0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], key_n};
            prev_q     <= sync_lvl;
            fill_q     <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            fall_pulse <= fill_q[SYNC_STAGES] & prev_q & ~sync_lvl;
        end
    end

endmodule

// File: rtl/genius_control.sv
// Genius game sequencing controller: Moore FSM driving datapath resets,
// enables and display select from game status flags and the enter key.
module genius_control
    import genius_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enter_n,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   enter_pulse;

    key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_edge (
        .clk_sys    (CLOCK_50),
        .reset      (reset),
        .key_n      (enter_n),
        .fall_pulse (enter_pulse)
    );

    // Next-state rules; the enter pulse only matters in SETUP and RESULT.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:      state_d = S_SETUP;
            S_SETUP:     state_d = enter_pulse ? S_PLAY_FPGA : S_SETUP;
            S_PLAY_FPGA: state_d = end_FPGA ? S_PLAY_USER : S_PLAY_FPGA;
            S_PLAY_USER: begin
                if (end_time)
                    state_d = S_RESULT;
                else if (end_User)
                    state_d = S_CHECK;
                else
                    state_d = S_PLAY_USER;
            end
            S_CHECK:     state_d = match ? S_NEXT_RND : S_RESULT;
            S_NEXT_RND:  state_d = S_CHECK_WIN;
            S_CHECK_WIN: state_d = win ? S_RESULT : S_PLAY_FPGA;
            S_RESULT:    state_d = enter_pulse ? S_INIT : S_RESULT;
            default:     state_d = S_INIT;
        endcase
    end

    // State register with outputs registered alongside it, so the outputs
    // always equal the decode of the current state and never glitch.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_INIT;
            ctrl_q  <= decode_ctrl(S_INIT);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
        end
    end

    assign R1      = ctrl_q.r1;
    assign R2      = ctrl_q.r2;
    assign E1      = ctrl_q.e1;
    assign E2      = ctrl_q.e2;
    assign E3      = ctrl_q.e3;
    assign E4      = ctrl_q.e4;
    assign SEL     = ctrl_q.sel;
    assign state_o = state_q;

endmodule

// File: tb/tb_genius_control.sv
// Self-checking bench for genius_control: directed scenarios plus a
// randomized play phase checked against a rule-level game model.
module tb_genius_control;

    localparam logic [2:0] T_INIT = 3'd0, T_SETUP = 3'd1, T_PFPGA = 3'd2, T_PUSER = 3'd3,
                           T_CHECK = 3'd4, T_NEXT = 3'd5, T_CWIN = 3'd6, T_RESULT = 3'd7;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       enter_n = 1'b1;
    logic       end_FPGA = 1'b0, end_User = 1'b0, end_time = 1'b0, win = 1'b0, match = 1'b0;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state_o;
    logic [6:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    genius_control #(.SYNC_STAGES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enter_n  (enter_n),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state_o  (state_o)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign obs = {R1, R2, E1, E2, E3, E4, SEL};

    // Expected {R1,R2,E1,E2,E3,E4,SEL} for each game state.
    function automatic logic [6:0] exp_ctrl(input logic [2:0] s);
        case (s)
            T_INIT:   return 7'b1100000;
            T_SETUP:  return 7'b0010001;
            T_PFPGA:  return 7'b0000101;
            T_PUSER:  return 7'b0001001;
            T_CHECK:  return 7'b0000001;
            T_NEXT:   return 7'b0100011;
            T_CWIN:   return 7'b0000001;
            default:  return 7'b0000000;
        endcase
    endfunction

    // Game rules for the key-independent phase of a round.
    function automatic logic [2:0] ref_next(input logic [2:0] s, input logic f, input logic u,
                                            input logic t, input logic m, input logic w);
        case (s)
            T_PFPGA: return f ? T_PUSER : T_PFPGA;
            T_PUSER: return t ? T_RESULT : (u ? T_CHECK : T_PUSER);
            T_CHECK: return m ? T_NEXT : T_RESULT;
            T_NEXT:  return T_CWIN;
            T_CWIN:  return w ? T_RESULT : T_PFPGA;
            default: return s;
        endcase
    endfunction

    task automatic clr_flags();
        end_FPGA = 1'b0; end_User = 1'b0; end_time = 1'b0; win = 1'b0; match = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge CLOCK_50);
            if (state_o == tgt) ok = 1'b1;
        end
    endtask

    // From SETUP: press and release enter, landing in PLAY_FPGA.
    task automatic to_play_fpga(output bit ok);
        clr_flags();
        enter_n = 1'b1;
        cyc(6);
        enter_n = 1'b0;
        wait_state(T_PFPGA, 20, ok);
        enter_n = 1'b1;
        cyc(6);
    endtask

    // From RESULT: press enter to restart, then start a new game.
    task automatic restart_game(output bit ok);
        bit a, b, c;
        clr_flags();
        enter_n = 1'b0;
        wait_state(T_INIT, 20, a);
        enter_n = 1'b1;
        wait_state(T_SETUP, 5, b);
        to_play_fpga(c);
        ok = a & b & c;
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1; enter_n = 1'b1; clr_flags();
        cyc(3);
        n_checks++;
        if ({state_o, obs} !== {T_INIT, exp_ctrl(T_INIT)})
            begin n_fail++; $display("FAIL reset_state: got %0d/%b want %0d/%b", state_o, obs, T_INIT, exp_ctrl(T_INIT)); end
        reset = 1'b0;
        n_checks++;
        if ({state_o, obs} !== {T_INIT, exp_ctrl(T_INIT)})
            begin n_fail++; $display("FAIL first_cycle_init: got %0d/%b want %0d/%b", state_o, obs, T_INIT, exp_ctrl(T_INIT)); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if ({state_o, obs} !== {T_SETUP, exp_ctrl(T_SETUP)}) bad = 1'b1;
        end
        n_checks++;
        if (bad)
            begin n_fail++; $display("FAIL setup_hold: got %0d/%b want %0d/%b", state_o, obs, T_SETUP, exp_ctrl(T_SETUP)); end
    endtask

    task automatic test_key_through_reset();
        reset = 1'b1; enter_n = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(20);
        n_checks++;
        if (state_o !== T_SETUP)
            begin n_fail++; $display("FAIL held_key_reset: state got %0d want %0d", state_o, T_SETUP); end
        enter_n = 1'b1;
        cyc(10);
        n_checks++;
        if (state_o !== T_SETUP)
            begin n_fail++; $display("FAIL held_key_release: state got %0d want %0d", state_o, T_SETUP); end
    endtask

    task automatic test_enter_hold();
        int entries;
        bit e3_bad;
        logic [2:0] prev;
        entries = 0; e3_bad = 1'b0; prev = state_o;
        enter_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (i == 19) enter_n = 1'b1;
            if (state_o == T_PFPGA && prev != T_PFPGA) entries++;
            if (state_o == T_PFPGA && obs !== exp_ctrl(T_PFPGA)) e3_bad = 1'b1;
            prev = state_o;
        end
        n_checks++;
        if (entries != 1)
            begin n_fail++; $display("FAIL hold_one_entry: entries got %0d want 1", entries); end
        n_checks++;
        if (state_o !== T_PFPGA || e3_bad)
            begin n_fail++; $display("FAIL hold_play_fpga: got %0d/%b want %0d/%b", state_o, obs, T_PFPGA, exp_ctrl(T_PFPGA)); end
    endtask

    task automatic test_ignored_enter();
        bit ok;
        enter_n = 1'b0; cyc(5);
        enter_n = 1'b1; cyc(10);
        n_checks++;
        if (state_o !== T_PFPGA)
            begin n_fail++; $display("FAIL enter_ignored: state got %0d want %0d", state_o, T_PFPGA); end
        end_FPGA = 1'b1; cyc(1);
        end_FPGA = 1'b0; end_time = 1'b1; cyc(1);
        end_time = 1'b0; cyc(10);
        n_checks++;
        if (state_o !== T_RESULT)
            begin n_fail++; $display("FAIL enter_not_queued: state got %0d want %0d", state_o, T_RESULT); end
        restart_game(ok);
        n_checks++;
        if (!ok)
            begin n_fail++; $display("FAIL restart_after_ignore: reached got 0 want 1"); end
    endtask

    task automatic test_full_round();
        logic [2:0] seq [5];
        int e4_cnt;
        seq = '{T_PUSER, T_CHECK, T_NEXT, T_CWIN, T_PFPGA};
        e4_cnt = 0;
        end_FPGA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            if (E4) e4_cnt++;
            n_checks++;
            if ({state_o, obs} !== {seq[i], exp_ctrl(seq[i])})
                begin n_fail++; $display("FAIL round_step%0d: got %0d/%b want %0d/%b", i, state_o, obs, seq[i], exp_ctrl(seq[i])); end
            if (i == 0) begin end_FPGA = 1'b0; end_User = 1'b1; match = 1'b1; win = 1'b0; end
            if (i == 1) end_User = 1'b0;
        end
        clr_flags();
        n_checks++;
        if (e4_cnt != 1)
            begin n_fail++; $display("FAIL round_e4_once: count got %0d want 1", e4_cnt); end
    endtask

    task automatic test_result_paths();
        bit ok;
        int e4_cnt;
        // end_time and end_User together: timeout wins
        end_FPGA = 1'b1; cyc(1);
        end_FPGA = 1'b0; end_time = 1'b1; end_User = 1'b1; cyc(1);
        n_checks++;
        if ({state_o, obs} !== {T_RESULT, exp_ctrl(T_RESULT)})
            begin n_fail++; $display("FAIL time_beats_user: got %0d/%b want %0d/%b", state_o, obs, T_RESULT, exp_ctrl(T_RESULT)); end
        restart_game(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL restart_after_time: reached got 0 want 1"); end
        // mismatch ends the game
        end_FPGA = 1'b1; cyc(1);
        end_FPGA = 1'b0; end_User = 1'b1; match = 1'b0; cyc(1);
        end_User = 1'b0; cyc(1);
        n_checks++;
        if (state_o !== T_RESULT)
            begin n_fail++; $display("FAIL mismatch_result: state got %0d want %0d", state_o, T_RESULT); end
        restart_game(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL restart_after_mismatch: reached got 0 want 1"); end
        // match then win ends the game with a single E4
        e4_cnt = 0;
        end_FPGA = 1'b1; cyc(1);
        end_FPGA = 1'b0; end_User = 1'b1; match = 1'b1; win = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            end_User = 1'b0;
            if (E4) e4_cnt++;
        end
        n_checks++;
        if (state_o !== T_RESULT || e4_cnt != 1)
            begin n_fail++; $display("FAIL win_result: state/e4 got %0d/%0d want %0d/1", state_o, e4_cnt, T_RESULT); end
        restart_game(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL restart_after_win: reached got 0 want 1"); end
    endtask

    task automatic test_reset_mid();
        end_FPGA = 1'b1; cyc(1);
        end_FPGA = 1'b0;
        n_checks++;
        if (state_o !== T_PUSER)
            begin n_fail++; $display("FAIL mid_reset_pre: state got %0d want %0d", state_o, T_PUSER); end
        reset = 1'b1; cyc(1);
        reset = 1'b0;
        n_checks++;
        if ({state_o, obs} !== {T_INIT, exp_ctrl(T_INIT)})
            begin n_fail++; $display("FAIL mid_reset_init: got %0d/%b want %0d/%b", state_o, obs, T_INIT, exp_ctrl(T_INIT)); end
        cyc(1);
        n_checks++;
        if ({state_o, obs} !== {T_SETUP, exp_ctrl(T_SETUP)})
            begin n_fail++; $display("FAIL mid_reset_setup: got %0d/%b want %0d/%b", state_o, obs, T_SETUP, exp_ctrl(T_SETUP)); end
    endtask

    task automatic test_random_play();
        bit ok;
        logic [2:0] exp_s;
        int bad_steps;
        to_play_fpga(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL random_start: reached got 0 want 1"); end
        exp_s = T_PFPGA;
        bad_steps = 0;
        for (int i = 0; i < 400; i++) begin
            if (exp_s == T_RESULT) begin
                restart_game(ok);
                n_checks++;
                if (!ok) begin n_fail++; $display("FAIL random_restart: reached got 0 want 1"); end
                exp_s = T_PFPGA;
            end else begin
                end_FPGA = ($urandom_range(0, 3) == 0);
                end_User = ($urandom_range(0, 3) == 0);
                end_time = ($urandom_range(0, 7) == 0);
                match    = ($urandom_range(0, 3) != 0);
                win      = ($urandom_range(0, 3) == 0);
                exp_s = ref_next(exp_s, end_FPGA, end_User, end_time, match, win);
                @(negedge CLOCK_50);
                n_checks++;
                if ({state_o, obs} !== {exp_s, exp_ctrl(exp_s)}) begin
                    n_fail++;
                    bad_steps++;
                    if (bad_steps <= 5)
                        $display("FAIL random_step%0d: got %0d/%b want %0d/%b", i, state_o, obs, exp_s, exp_ctrl(exp_s));
                end
            end
        end
        clr_flags();
    endtask

    initial begin
        test_reset();
        test_key_through_reset();
        test_enter_hold();
        test_ignored_enter();
        test_full_round();
        test_result_paths();
        test_reset_mid();
        test_random_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
